// File: rtl/in_pass4_sync_filter.sv
// Four-channel input pass BEL: pad inputs cross into the UserCLK domain through
// a 2-flop synchronizer, then a per-channel debouncer and rising-edge detector.
module in_pass4_sync_filter #(
  parameter int NoConfigBits    = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                    UserCLK,
  input  logic                    UserRST,
  input  logic [3:0]              I,
  output logic [3:0]              O,
  input  logic [NoConfigBits-1:0] ConfigBits
);

  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_SYNC   = 2'b01;
  localparam logic [1:0] MODE_LEVEL  = 2'b10;
  localparam logic [1:0] MODE_PULSE  = 2'b11;

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  for (genvar k = 0; k < 4; k++) begin : g_chan
    logic       s1;
    logic       s2;
    logic       db;
    logic       db_q;
    logic [7:0] cnt;
    logic [1:0] mode;
    logic       chan_out;

    // State runs in every mode so a mode change never disturbs timing.
    always_ff @(posedge UserCLK) begin
      if (UserRST) begin
        s1   <= 1'b0;
        s2   <= 1'b0;
        db   <= 1'b0;
        db_q <= 1'b0;
        cnt  <= 8'd0;
      end else begin
        s1   <= I[k];
        s2   <= s1;
        db_q <= db;
        if (s2 == db) begin
          cnt <= 8'd0;
        end else if (cnt >= CNT_LAST) begin
          db  <= s2;
          cnt <= 8'd0;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end

    assign mode = ConfigBits[2*k +: 2];

    always_comb begin
      chan_out = 1'b0;
      case (mode)
        MODE_BYPASS: chan_out = I[k];
        MODE_SYNC:   chan_out = s2;
        MODE_LEVEL:  chan_out = db;
        MODE_PULSE:  chan_out = db & ~db_q;
        default:     chan_out = 1'b0;
      endcase
    end

    assign O[k] = chan_out;
  end

endmodule

// File: tb/tb_in_pass4_sync_filter.sv
// Directed bench for in_pass4_sync_filter with hand-computed edge-by-edge
// expectations for DEBOUNCE_CYCLES = 4.
module tb_in_pass4_sync_filter;

  logic       UserCLK = 1'b0;
  logic       UserRST;
  logic [3:0] I;
  logic [3:0] O;
  logic [7:0] ConfigBits;

  int checkCount = 0;
  int errorCount = 0;

  // ch3 sync, ch2 level, ch1 pulse, ch0 level
  localparam logic [7:0] BASE_CFG = 8'b01_10_11_10;

  in_pass4_sync_filter #(
    .NoConfigBits(8),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .UserCLK(UserCLK),
    .UserRST(UserRST),
    .I(I),
    .O(O),
    .ConfigBits(ConfigBits)
  );

  always #5 UserCLK = ~UserCLK;

  task automatic stepEdge();
    @(posedge UserCLK);
    #1;
  endtask

  task automatic applyStimulus(input logic rst, input logic [3:0] inVal);
    UserRST = rst;
    I       = inVal;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] observed,
                             input logic [3:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  bit pat3 [12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    ConfigBits = BASE_CFG;
    applyStimulus(1'b1, 4'b0000);
    repeat (2) stepEdge();
    checkOutput("reset_state", O, 4'b0000);

    // Release with all pins low: no pulse, nothing moves.
    applyStimulus(1'b0, 4'b0000);
    for (int e = 0; e < 3; e++) begin
      stepEdge();
      checkOutput($sformatf("release_low_e%0d", e), O, 4'b0000);
    end

    // ch0 level and ch1 pulse: I rises before edge 0, db rises on edge 5.
    applyStimulus(1'b0, 4'b0011);
    for (int e = 0; e < 8; e++) begin
      stepEdge();
      checkOutput($sformatf("ch0_level_e%0d", e), 4'(O[0]), 4'(e >= 5));
      checkOutput($sformatf("ch1_pulse_e%0d", e), 4'(O[1]), 4'(e == 5));
    end
    checkOutput("ch23_idle", {2'b00, O[3], O[2]}, 4'b0000);

    // ch1 falls: no pulse on the debounced falling edge.
    applyStimulus(1'b0, 4'b0001);
    for (int e = 0; e < 8; e++) begin
      stepEdge();
      checkOutput($sformatf("ch1_fall_e%0d", e), 4'(O[1]), 4'b0000);
      checkOutput($sformatf("ch0_hold_e%0d", e), 4'(O[0]), 4'b0001);
    end
    applyStimulus(1'b0, 4'b0000);
    for (int e = 0; e < 8; e++) begin
      stepEdge();
      checkOutput($sformatf("ch0_fall_e%0d", e), 4'(O[0]), 4'(e < 5));
    end

    // ch2: a 3-cycle glitch must not reach db.
    applyStimulus(1'b0, 4'b0100);
    for (int e = 0; e < 8; e++) begin
      stepEdge();
      checkOutput($sformatf("ch2_glitch_e%0d", e), 4'(O[2]), 4'b0000);
      if (e == 2) applyStimulus(1'b0, 4'b0000);
    end
    // ch2: 4 cycles high is accepted on edge 5, released on edge 9.
    applyStimulus(1'b0, 4'b0100);
    for (int e = 0; e < 11; e++) begin
      stepEdge();
      checkOutput($sformatf("ch2_accept_e%0d", e), 4'(O[2]), 4'(e >= 5 && e <= 8));
      if (e == 3) applyStimulus(1'b0, 4'b0000);
    end

    // ch3 sync mode: O follows the pin value driven two edges earlier.
    for (int e = 0; e < 12; e++) begin
      applyStimulus(1'b0, {pat3[e], 3'b000});
      stepEdge();
      checkOutput($sformatf("ch3_sync_e%0d", e), 4'(O[3]), 4'((e == 0) ? 1'b0 : pat3[e-1]));
    end
    applyStimulus(1'b0, 4'b0000);
    repeat (8) stepEdge();

    // ch3 bypass: zero latency, also while reset is held.
    ConfigBits = BASE_CFG & 8'b00_11_11_11;
    applyStimulus(1'b0, 4'b1000);
    #1;
    checkOutput("ch3_bypass_hi", 4'(O[3]), 4'b0001);
    applyStimulus(1'b0, 4'b0000);
    #1;
    checkOutput("ch3_bypass_lo", 4'(O[3]), 4'b0000);
    applyStimulus(1'b1, 4'b0000);
    stepEdge();
    applyStimulus(1'b1, 4'b1000);
    #1;
    checkOutput("bypass_in_reset_hi", O, 4'b1000);
    applyStimulus(1'b1, 4'b0000);
    #1;
    checkOutput("bypass_in_reset_lo", O, 4'b0000);

    // Reset mid-debounce on ch0 discards the partial count.
    ConfigBits = BASE_CFG;
    stepEdge();
    applyStimulus(1'b0, 4'b0001);
    for (int e = 0; e < 4; e++) begin
      stepEdge();
      checkOutput($sformatf("ch0_pre_reset_e%0d", e), 4'(O[0]), 4'b0000);
    end
    applyStimulus(1'b1, 4'b0001);
    repeat (2) stepEdge();
    checkOutput("mid_reset_state", O, 4'b0000);
    applyStimulus(1'b0, 4'b0001);
    for (int e = 1; e <= 5; e++) begin
      stepEdge();
      checkOutput($sformatf("ch0_refill_e%0d", e), 4'(O[0]), 4'b0000);
      if (e == 3) begin
        ConfigBits[1:0] = 2'b11;
        #1;
        checkOutput("ch0_mode11_midcount", 4'(O[0]), 4'b0000);
      end
      if (e == 4) begin
        ConfigBits[1:0] = 2'b10;
        #1;
        checkOutput("ch0_mode10_back", 4'(O[0]), 4'b0000);
      end
    end
    stepEdge();
    checkOutput("ch0_refill_e6", 4'(O[0]), 4'b0001);
    ConfigBits[1:0] = 2'b11;
    #1;
    checkOutput("ch0_release_pulse_e6", 4'(O[0]), 4'b0001);
    stepEdge();
    checkOutput("ch0_release_pulse_e7", 4'(O[0]), 4'b0000);
    ConfigBits[1:0] = 2'b10;
    #1;
    checkOutput("ch0_level_e7", 4'(O[0]), 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/in_pass4_sync_filter.md
IN_PASS4_SYNC_FILTER -- requirements
Module: in_pass4_sync_filter

Interface
REQ-001 Parameter NoConfigBits, default 8: configuration width; 2 bits per channel.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: consecutive-mismatch count needed to update the debounced level; legal range 2..255.
REQ-003 UserCLK  input  1  single clock for all state; EXTERNAL, SHARED_PORT.
REQ-004 UserRST  input  1  synchronous, active-high reset, sampled on UserCLK rising edge.
REQ-005 I  input  4  pad-side inputs from top level; EXTERNAL; asynchronous to UserCLK.
REQ-006 O  output  4  fabric-side outputs to switch matrix.
REQ-007 ConfigBits  input  NoConfigBits  GLOBAL; channel k mode = ConfigBits[2k+1:2k].

Function
REQ-008 The block SHALL be the input-direction counterpart of the output pass BEL: external pins in, fabric signals out, 4 independent identical channels.
REQ-009 Each channel SHALL hold a 2-flop synchronizer: s1 <= I[k], s2 <= s1 on every UserCLK rising edge.
REQ-010 Each channel SHALL hold debounced level db and an 8-bit counter cnt.
REQ-011 If s2 == db: cnt <= 0, db holds.
REQ-012 If s2 != db and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1, db holds.
REQ-013 If s2 != db and cnt == DEBOUNCE_CYCLES-1: db <= s2, cnt <= 0; db thus updates on the DEBOUNCE_CYCLES-th consecutive edge with s2 != db.
REQ-014 Any edge with s2 == db before the threshold SHALL clear cnt; glitches shorter than DEBOUNCE_CYCLES cycles at s2 never reach db.
REQ-015 Each channel SHALL hold db_q <= db (one-cycle delayed copy) for edge detection.
REQ-016 Mode 00: O[k] = I[k] combinationally (bypass; unaffected by clock or reset).
REQ-017 Mode 01: O[k] = s2 (synchronized level, 2-edge latency).
REQ-018 Mode 10: O[k] = db (debounced level).
REQ-019 Mode 11: O[k] = db & ~db_q (one-cycle pulse on debounced rising edge; falling edges produce no pulse).
REQ-020 Synchronizer, debounce and edge state SHALL run every cycle regardless of mode; a ConfigBits change only switches the output mux and SHALL NOT reset or disturb any channel state.
REQ-021 Channels SHALL share no state; activity on one channel SHALL NOT affect another.
REQ-022 cnt SHALL never exceed DEBOUNCE_CYCLES-1 (no wrap-around).
REQ-023 All outputs in modes 01/10/11 SHALL be driven directly from registers or a 2-input AND of registers (no path from I).

Reset
REQ-024 With UserRST high at a clock edge, s1, s2, db, db_q and cnt of every channel SHALL become 0 on that edge.
REQ-025 Output values during/after reset: modes 01, 10, 11 read 0; mode 00 follows I.
REQ-026 Reset asserted mid-debounce SHALL discard the partial count; no pulse SHALL be generated by reset release while I is low.
REQ-027 If I is high at reset release, db SHALL rise on edge 2+DEBOUNCE_CYCLES after release (sync refill plus full debounce) and mode 11 SHALL then emit one pulse.

Verification
REQ-028 Reset, all modes 10, DEBOUNCE_CYCLES=4; I[0] 0->1 before edge 0, held -> s2=1 after edge 1, O[0]=1 after edge 5, not earlier.
REQ-029 Mode 11 on channel 1, same stimulus -> O[1] high for exactly one cycle (edge 5 to edge 6); I[1] 1->0 later -> no pulse.
REQ-030 Mode 10; I[2] high for 3 cycles then low -> O[2] stays 0, cnt returns to 0; then high for 4 cycles (as seen at s2) -> O[2]=1.
REQ-031 Mode 01 on channel 3 with I[3] toggling every 2 cycles -> O[3] equals I[3] delayed 2 edges; mode 00 -> O[3] follows I[3] with zero latency, including during UserRST high.
REQ-032 Assert UserRST at cnt=2 with I[0]=1, release with I[0]=1 -> O[0] (mode 10) 0 until edge 6 after release; switching channel 0 mode 10->11->10 mid-count does not alter the debounce timing.
